accel_sampler: RTL and testbench

Autonomous AHB-Lite slave that periodically reads the X/Y/Z 8-bit acceleration registers of the ADXL362 over SPI without CPU involvement. It sits in place of the CPU-driven SPI master on the accelerometer pins and generates CS, SCLK and MOSI itself. It samples MISO and presents the latest atomic sample, status flags and an interrupt on the AHB bus.

---
 rtl/accel_sampler.sv | 126 ++++++++++++
 tb/tb_accel_sampler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/accel_sampler.sv
// accel_sampler: AHB-Lite slave that autonomously bursts ADXL362 X/Y/Z reads over SPI
module accel_sampler #(
  parameter logic [15:0] DEFAULT_PERIOD = 16'd50000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        ACCEL_CS_N,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  localparam logic [39:0] FRAME = 40'h0B_08_00_00_00;
  state_t      state, state_n;
  logic [9:0]  cnt, cnt_n;
  logic [15:0] timer, timer_n, period;
  logic        wr_q, rd_q;
  logic [1:0]  addr_q;
  logic        en, irqen, irqen_n, new_f, new_n, ovr, ovr_n;
  logic [23:0] rx, data;
  logic        wr_ctrl, wr_status, wr_period, rd_data, busy, load, sample;
  logic        unused;
  assign unused    = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};
  assign wr_ctrl   = wr_q && addr_q == 2'd0;
  assign wr_status = wr_q && addr_q == 2'd1;
  assign wr_period = wr_q && addr_q == 2'd3;
  assign rd_data   = rd_q && addr_q == 2'd2;
  assign busy      = state != IDLE;
  assign load      = state == SHIFT && cnt == 10'd639;
  assign sample    = state == SHIFT && cnt[3:0] == 4'd8;
  assign irqen_n   = wr_ctrl ? HWDATA[1] : irqen;
  assign new_n     = load || (new_f && !rd_data);
  assign ovr_n     = (load && new_f && !rd_data) || (ovr && !(wr_status && HWDATA[2]));
  // Burst sequencer: idle timer, then SETUP/SHIFT/HOLD counted on a shared cycle counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 10'd1;
    timer_n = '0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        timer_n = (en && timer != period) ? timer + 16'd1 : '0;
        state_n = (en && timer == period) ? SETUP : IDLE;
      end
      SETUP: if (cnt == 10'd15) begin
        state_n = SHIFT;
        cnt_n   = '0;
      end
      SHIFT: if (cnt == 10'd639) begin
        state_n = HOLD;
        cnt_n   = '0;
      end
      default: if (cnt == 10'd15) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  // Sequencer state register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      timer <= timer_n;
    end
  end
  // AHB address-phase capture and software-visible control/status registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 2'd0;
      en     <= 1'b0;
      irqen  <= 1'b0;
      period <= DEFAULT_PERIOD;
      new_f  <= 1'b0;
      ovr    <= 1'b0;
      IRQ    <= 1'b0;
    end else begin
      if (HREADY) begin
        wr_q   <= HSEL && HWRITE && HTRANS[1];
        rd_q   <= HSEL && !HWRITE && HTRANS[1];
        addr_q <= HADDR[3:2];
      end
      if (wr_ctrl) en <= HWDATA[0];
      if (wr_period) period <= HWDATA[15:0];
      irqen <= irqen_n;
      new_f <= new_n;
      ovr   <= ovr_n;
      IRQ   <= irqen_n && new_n;
    end
  end
  // SPI pins driven from the upcoming state; MISO shifted in on SCLK rise, sample latched at end of SHIFT
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ACCEL_CS_N <= 1'b1;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      rx         <= '0;
      data       <= '0;
    end else begin
      ACCEL_CS_N <= state_n == IDLE;
      SCLK       <= state_n == SHIFT && cnt_n[3];
      if (state_n == SHIFT && cnt_n[3:0] == 4'd0) MOSI <= FRAME[6'd39 - cnt_n[9:4]];
      if (sample) rx <= {rx[22:0], MISO};
      if (load) data <= {rx[7:0], rx[15:8], rx[23:16]};
    end
  end
  // Read mux on the registered data-phase address
  always_comb
    HRDATA = addr_q == 2'd0 ? {30'd0, irqen, en} :
             addr_q == 2'd1 ? {29'd0, ovr, new_f, busy} :
             addr_q == 2'd2 ? {8'h00, data} : {16'h0000, period};
endmodule

// File: tb/tb_accel_sampler.sv
// tb_accel_sampler: directed/randomized bench for accel_sampler with an ADXL362 MISO model
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))
module tb_accel_sampler;
  logic        HCLK, HRESETn, HSEL, HREADY, HWRITE, MISO;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        SCLK, MOSI, ACCEL_CS_N, IRQ;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0]  mx, my, mz;
  logic [39:0] sh, mosi_sr;
  logic [31:0] r, exp_d, old_d;
  int n_rise, bad_per, first_rise, last_rise, cs_fall_t, irq_rise_t;
  int t_en, t_fall, t_rise, t_next, lows;
  logic cs_prev, sclk_prev, irq_prev;

  accel_sampler dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .ACCEL_CS_N(ACCEL_CS_N), .IRQ(IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
    HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10; HADDR = {28'd0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [1:0] a, output logic [31:0] d);
    HSEL = 1'b1; HWRITE = 1'b0; HTRANS = 2'b10; HADDR = {28'd0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic wait_cs(input logic lvl, input int max, output int t);
    int k;
    k = 0;
    while (ACCEL_CS_N !== lvl && k < max) begin
      @(negedge HCLK);
      k++;
    end
    t = cyc;
    `CHK("cs_wait", ACCEL_CS_N, lvl);
  endtask

  task automatic pick_sample();
    mx = 8'($urandom_range(0, 255));
    my = 8'($urandom_range(0, 255));
    mz = 8'($urandom_range(0, 255));
  endtask

  // ADXL362 model: drives the 40-bit response MSB first, advancing on each SCLK fall (mode 0)
  initial begin
    MISO = 1'b0;
    forever begin
      @(negedge ACCEL_CS_N);
      sh = {16'h0000, mx, my, mz};
      MISO = sh[39];
      while (!ACCEL_CS_N) begin
        @(negedge SCLK or posedge ACCEL_CS_N);
        sh = sh << 1;
        MISO = sh[39];
      end
    end
  end

  // SPI/IRQ monitor sampled mid-cycle
  initial begin
    cs_prev = 1'b1; sclk_prev = 1'b0; irq_prev = 1'b0;
    n_rise = 0; bad_per = 0; first_rise = -1; last_rise = 0; cs_fall_t = 0; irq_rise_t = 0;
    mosi_sr = '0;
    forever begin
      @(negedge HCLK);
      if (cs_prev && !ACCEL_CS_N) begin
        n_rise = 0; bad_per = 0; first_rise = -1; mosi_sr = '0; cs_fall_t = cyc;
      end
      if (!sclk_prev && SCLK) begin
        if (n_rise == 0) first_rise = cyc - cs_fall_t;
        else if (cyc - last_rise != 16) bad_per++;
        last_rise = cyc;
        n_rise++;
        mosi_sr = {mosi_sr[38:0], MOSI};
      end
      if (!irq_prev && IRQ) irq_rise_t = cyc;
      cs_prev = ACCEL_CS_N; sclk_prev = SCLK; irq_prev = IRQ;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0;
    mx = 8'h00; my = 8'h00; mz = 8'h00;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    `CHK("rst_cs_n", ACCEL_CS_N, 1'b1);
    `CHK("rst_sclk", SCLK, 1'b0);
    `CHK("rst_mosi", MOSI, 1'b0);
    `CHK("rst_irq", IRQ, 1'b0);
    `CHK("rst_hrdata", HRDATA, 32'd0);
    ahb_read(2'd0, r); `CHK("rst_ctrl", r, 32'd0);
    ahb_read(2'd1, r); `CHK("rst_status", r, 32'd0);
    ahb_read(2'd2, r); `CHK("rst_data", r, 32'd0);
    ahb_read(2'd3, r); `CHK("rst_period", r, 32'd50000);
    // burst 1: fixed sample, full timing and frame checks
    mx = 8'h12; my = 8'h34; mz = 8'h56;
    ahb_write(2'd3, 32'd100);
    ahb_write(2'd0, 32'd3);
    t_en = cyc + 1;
    wait_cs(1'b0, 300, t_fall);
    `CHK("first_fall_delay", t_fall - t_en, 101);
    wait_cs(1'b1, 800, t_rise);
    `CHK("cs_low_cycles", t_rise - t_fall, 672);
    `CHK("data_visible_delay", irq_rise_t - t_fall, 656);
    `CHK("first_sclk_rise", first_rise, 24);
    `CHK("sclk_pulses", n_rise, 40);
    `CHK("sclk_period_errs", bad_per, 0);
    `CHK("mosi_frame", mosi_sr, 40'h0B08000000);
    `CHK("irq_set", IRQ, 1'b1);
    ahb_read(2'd1, r); `CHK("status_new", r, 32'd2);
    ahb_read(2'd2, r); `CHK("data_b1", r, 32'h00563412);
    `CHK("irq_at_read", IRQ, 1'b1);
    @(negedge HCLK);
    `CHK("irq_drop", IRQ, 1'b0);
    // bursts 2 and 3: NEW left set produces an overrun
    pick_sample();
    wait_cs(1'b0, 300, t_next);
    `CHK("burst_spacing", t_next - t_fall, 773);
    wait_cs(1'b1, 800, t_rise);
    pick_sample();
    exp_d = {8'h00, mz, my, mx};
    wait_cs(1'b0, 300, t_next);
    wait_cs(1'b1, 800, t_rise);
    ahb_read(2'd1, r); `CHK("status_ovr", r, 32'd6);
    ahb_write(2'd1, 32'd4);
    ahb_read(2'd1, r); `CHK("status_ovr_clr", r, 32'd2);
    ahb_read(2'd2, r); `CHK("data_b3", r, exp_d);
    // burst 4: EN cleared at bit 20, burst still completes
    pick_sample();
    exp_d = {8'h00, mz, my, mx};
    wait_cs(1'b0, 300, t_fall);
    repeat (336) @(negedge HCLK);
    ahb_write(2'd0, 32'd2);
    ahb_read(2'd1, r); `CHK("status_busy", r, 32'd1);
    wait_cs(1'b1, 800, t_rise);
    `CHK("cs_low_en_off", t_rise - t_fall, 672);
    ahb_read(2'd1, r); `CHK("status_en_off", r, 32'd2);
    ahb_read(2'd2, r); `CHK("data_b4", r, exp_d);
    lows = 0;
    repeat (300) begin
      @(negedge HCLK);
      if (ACCEL_CS_N !== 1'b1) lows++;
    end
    `CHK("no_burst_en_off", lows, 0);
    // bursts 5 and 6: DATA read on the exact load cycle
    pick_sample();
    old_d = {8'h00, mz, my, mx};
    ahb_write(2'd0, 32'd3);
    wait_cs(1'b0, 300, t_fall);
    wait_cs(1'b1, 800, t_rise);
    pick_sample();
    exp_d = {8'h00, mz, my, mx};
    wait_cs(1'b0, 300, t_fall);
    repeat (654) @(negedge HCLK);
    ahb_read(2'd2, r); `CHK("data_at_load_old", r, old_d);
    ahb_read(2'd1, r); `CHK("status_read_vs_load", r, 32'd3);
    ahb_read(2'd2, r); `CHK("data_b6", r, exp_d);
    wait_cs(1'b1, 800, t_rise);
    // bursts 7 and 8: OVR clear on the exact overrun cycle
    pick_sample();
    wait_cs(1'b0, 300, t_fall);
    wait_cs(1'b1, 800, t_rise);
    pick_sample();
    exp_d = {8'h00, mz, my, mx};
    wait_cs(1'b0, 300, t_fall);
    repeat (654) @(negedge HCLK);
    ahb_write(2'd1, 32'd4);
    ahb_read(2'd1, r); `CHK("status_clr_vs_ovr", r, 32'd7);
    wait_cs(1'b1, 800, t_rise);
    ahb_read(2'd2, r); `CHK("data_b8", r, exp_d);
    // burst 9: reset at bit 30 discards the partial sample
    pick_sample();
    wait_cs(1'b0, 300, t_fall);
    repeat (506) @(negedge HCLK);
    `CHK("sclk_high_pre_rst", SCLK, 1'b1);
    HRESETn = 1'b0;
    @(negedge HCLK);
    `CHK("mid_rst_cs_n", ACCEL_CS_N, 1'b1);
    `CHK("mid_rst_sclk", SCLK, 1'b0);
    `CHK("mid_rst_mosi", MOSI, 1'b0);
    `CHK("mid_rst_irq", IRQ, 1'b0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    ahb_read(2'd2, r); `CHK("post_rst_data", r, 32'd0);
    ahb_read(2'd1, r); `CHK("post_rst_status", r, 32'd0);
    ahb_read(2'd0, r); `CHK("post_rst_ctrl", r, 32'd0);
    ahb_read(2'd3, r); `CHK("post_rst_period", r, 32'd50000);
    lows = 0;
    repeat (200) begin
      @(negedge HCLK);
      if (ACCEL_CS_N !== 1'b1) lows++;
    end
    `CHK("no_burst_post_rst", lows, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
